// File: rtl/ccd_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ccd_rx_pkg
// Description : Shared types and default geometry for the CCD pixel receiver.
//               Holds the capture FSM state encoding, the FIFO entry layout
//               and the default sensor geometry constants.
// Revision    : 1.0 - initial release
// ============================================================================
package ccd_rx_pkg;

  // Default geometry of the sensor this receiver is paired with.
  localparam int DEF_PIX_W      = 16;
  localparam int DEF_H_ACTIVE   = 2048;
  localparam int DEF_V_ACTIVE   = 1536;
  localparam int DEF_CNT_W      = 13;
  localparam int DEF_FIFO_DEPTH = 16;

  // Capture FSM states.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    IN_FRAME   = 2'd2
  } rx_state_t;

  // One output FIFO entry. The data field is DEF_PIX_W wide; the receiver's
  // PIX_W must not exceed it.
  typedef struct packed {
    logic                 sof;
    logic                 eol;
    logic [DEF_PIX_W-1:0] data;
  } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/ccd_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ccd_rx_fifo
// Description : Synchronous first-word-fall-through FIFO. The head entry is
//               presented on rd_data whenever empty is low.
// Ports       : clk_pix, rst       - clock, async active-high pointer reset
//               wr_en, wr_data     - push request and data
//               rd_en, rd_data     - pop request and head-of-queue data
//               full, empty        - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module ccd_rx_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_rd;
  logic             w_do_wr;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_rd = rd_en && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_do_wr = wr_en && (!full || w_do_rd);
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible until a pointer moves.
  always_ff @(posedge clk_pix) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/ccd_pix_rx.sv
`default_nettype none
// ============================================================================
// Module      : ccd_pix_rx
// Description : CCD/AFE pixel capture. Samples pixels framed by vsync/hsync,
//               checks line and frame geometry, and streams pixels tagged with
//               start-of-frame / end-of-line through an FWFT FIFO.
// Ports       : clk_pix, rst                 - clock, async active-high reset
//               enable, clear_err            - capture enable, error clear
//               vsync, hsync, pix_data       - AFE pins
//               out_data/sof/eol/valid/ready - output stream
//               busy, frame_done, last_lines - capture status
//               err_line_len/frame_len/overflow - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module ccd_pix_rx
  import ccd_rx_pkg::*;
#(
  parameter int PIX_W      = DEF_PIX_W,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear_err,
  input  logic             vsync,
  input  logic             hsync,
  input  logic [PIX_W-1:0] pix_data,
  output logic [PIX_W-1:0] out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] last_lines,
  output logic             err_line_len,
  output logic             err_frame_len,
  output logic             err_overflow
);

  localparam logic [CNT_W-1:0] c_h_active = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_v_active = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;

  rx_state_t        r_state;
  logic             r_vsync;
  logic             r_hsync;
  logic [PIX_W-1:0] r_pix;
  logic             r_sof_arm;
  logic [CNT_W-1:0] r_pix_cnt;
  logic [CNT_W-1:0] r_line_cnt;
  logic [CNT_W-1:0] r_last_lines;
  logic             r_frame_done;
  logic             r_err_line;
  logic             r_err_frame;
  logic             r_err_ovf;

  logic             w_in_frame;
  logic             w_pix_valid;
  logic             w_line_end;
  logic             w_frame_end;
  logic [CNT_W-1:0] w_pix_cnt_nxt;
  logic [CNT_W-1:0] w_line_cnt_nxt;
  logic             w_wr_en;
  logic             w_rd_en;
  logic             w_full;
  logic             w_empty;
  logic             w_new_line_err;
  logic             w_new_frame_err;
  logic             w_new_ovf;
  fifo_entry_t      w_wr_entry;
  fifo_entry_t      w_rd_entry;

  // The input register holds the pending pixel; the pins at the next edge
  // tell whether it was the last of its line (hsync or vsync going low).
  assign w_in_frame  = (r_state == IN_FRAME);
  assign w_pix_valid = r_vsync && r_hsync;
  assign w_line_end  = w_pix_valid && !(vsync && hsync);
  assign w_frame_end = r_vsync && !vsync;

  // Saturating counters; a saturated count still mismatches the geometry.
  assign w_pix_cnt_nxt  = !w_pix_valid ? r_pix_cnt :
                          (r_pix_cnt == c_cnt_max) ? r_pix_cnt : r_pix_cnt + 1'b1;
  assign w_line_cnt_nxt = !w_line_end ? r_line_cnt :
                          (r_line_cnt == c_cnt_max) ? r_line_cnt : r_line_cnt + 1'b1;

  assign w_wr_en = w_in_frame && w_pix_valid;
  assign w_rd_en = !w_empty && out_ready;

  assign w_new_line_err  = w_in_frame && w_line_end  && (w_pix_cnt_nxt  != c_h_active);
  assign w_new_frame_err = w_in_frame && w_frame_end && (w_line_cnt_nxt != c_v_active);
  assign w_new_ovf       = w_wr_en && w_full && !w_rd_en;

  always_comb begin
    w_wr_entry      = '0;
    w_wr_entry.sof  = r_sof_arm;
    w_wr_entry.eol  = w_line_end;
    w_wr_entry.data = DEF_PIX_W'(r_pix);
  end

  ccd_rx_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_pix (clk_pix),
    .rst     (rst),
    .wr_en   (w_wr_en),
    .wr_data (w_wr_entry),
    .rd_en   (w_rd_en),
    .rd_data (w_rd_entry),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Stream fields read as zero while nothing is queued.
  assign out_valid     = !w_empty;
  assign out_data      = w_empty ? '0 : PIX_W'(w_rd_entry.data);
  assign out_sof       = !w_empty && w_rd_entry.sof;
  assign out_eol       = !w_empty && w_rd_entry.eol;
  assign busy          = w_in_frame;
  assign frame_done    = r_frame_done;
  assign last_lines    = r_last_lines;
  assign err_line_len  = r_err_line;
  assign err_frame_len = r_err_frame;
  assign err_overflow  = r_err_ovf;

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_vsync      <= 1'b0;
      r_hsync      <= 1'b0;
      r_pix        <= '0;
      r_sof_arm    <= 1'b0;
      r_pix_cnt    <= '0;
      r_line_cnt   <= '0;
      r_last_lines <= '0;
      r_frame_done <= 1'b0;
      r_err_line   <= 1'b0;
      r_err_frame  <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      r_vsync      <= vsync;
      r_hsync      <= hsync;
      r_pix        <= pix_data;
      r_frame_done <= 1'b0;
      // A new error in the clearing cycle keeps the flag set.
      r_err_line   <= (r_err_line  && !clear_err) || w_new_line_err;
      r_err_frame  <= (r_err_frame && !clear_err) || w_new_frame_err;
      r_err_ovf    <= (r_err_ovf   && !clear_err) || w_new_ovf;

      case (r_state)
        IDLE: begin
          // Only arm between frames so capture never starts mid-frame.
          if (enable && !r_vsync) r_state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (!enable) begin
            r_state <= IDLE;
          end else if (!r_vsync && vsync) begin
            r_state    <= IN_FRAME;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_sof_arm  <= 1'b1;
          end
        end
        IN_FRAME: begin
          // SOF goes to the first pixel offered, even if it gets dropped.
          if (w_pix_valid) r_sof_arm <= 1'b0;
          r_pix_cnt  <= w_line_end ? '0 : w_pix_cnt_nxt;
          r_line_cnt <= w_line_cnt_nxt;
          if (w_frame_end) begin
            r_last_lines <= w_line_cnt_nxt;
            r_frame_done <= 1'b1;
            r_state      <= enable ? WAIT_FRAME : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
